// File: rtl/ldpc_pkg.sv
// ============================================================================
// Package     : ldpc_pkg
// Description : Shared LDPC code geometry and codeword-serializer FSM type.
//               LDPC_WORD_LENGTH = LDPC_INFO_LENGTH + LDPC_PARITY_SIZE, and
//               the serializer walks a codeword in NUM_CHUNKS beats of Z bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ldpc_pkg;

  localparam int LDPC_WORD_LENGTH = 648;
  localparam int LDPC_INFO_LENGTH = 486;
  localparam int LDPC_PARITY_SIZE = 162;
  localparam int Z                = 27;
  localparam int NUM_CHUNKS       = LDPC_WORD_LENGTH / Z;

  // Chunk index width; the out_idx port is fixed at 5 bits, so at most 32 chunks.
  localparam int IDX_W            = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage : ldpc_pkg

`default_nettype wire

// File: rtl/ldpc_cw_serializer.sv
// ============================================================================
// Module      : ldpc_cw_serializer
// Description : Captures a parallel LDPC codeword and streams it out as
//               NUM_CHUNKS beats of Z bits, chunk 0 (LSBs) first, under a
//               valid/ready handshake. A new codeword can be accepted in the
//               same cycle the last beat transfers, so back-to-back words
//               stream with no bubble.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous reset, active low
//               cw_valid   - upstream has a complete codeword on codeword
//               codeword   - parallel codeword, bits [Z-1:0] are chunk 0
//               cw_ready   - codeword is captured this cycle if cw_valid
//               out_valid  - out_data holds a valid chunk
//               out_ready  - downstream accepts the chunk this cycle
//               out_data   - current Z-bit chunk
//               out_idx    - index of the current chunk
//               out_last   - current chunk is the final one
//               cw_drop    - pulses the cycle after cw_valid was refused
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ldpc_cw_serializer
  import ldpc_pkg::*;
#(
  parameter int LDPC_WORD_LENGTH = ldpc_pkg::LDPC_WORD_LENGTH,
  parameter int Z                = ldpc_pkg::Z
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cw_valid,
  input  logic [LDPC_WORD_LENGTH-1:0] codeword,
  output logic                        cw_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [Z-1:0]                out_data,
  output logic [4:0]                  out_idx,
  output logic                        out_last,
  output logic                        cw_drop
);

  localparam int               NUM_CHUNKS = LDPC_WORD_LENGTH / Z;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CHUNKS - 1);

  // Geometry must split into whole chunks that the 5-bit index can address.
  generate
    if (((LDPC_WORD_LENGTH % Z) != 0) || (NUM_CHUNKS > 32) || (NUM_CHUNKS < 1)) begin : g_bad_geometry
      $error("ldpc_cw_serializer: LDPC_WORD_LENGTH/Z must be an integer in 1..32");
    end
  endgenerate

  state_t                      r_state;
  logic [LDPC_WORD_LENGTH-1:0] r_hold;
  logic [IDX_W-1:0]            r_idx;
  logic                        r_drop;

  logic                        w_out_valid;
  logic                        w_at_last;
  logic                        w_xfer;
  logic                        w_cw_ready;
  logic                        w_capture;
  logic [Z-1:0]                w_chunk;

  assign w_out_valid = (r_state == ST_SEND);
  assign w_at_last   = (r_idx == LAST_IDX);
  assign w_xfer      = w_out_valid && out_ready;

  // Ready is gated by rst so that nothing is advertised while in reset.
  assign w_cw_ready  = rst && ((r_state == ST_IDLE) || (w_xfer && w_at_last));
  assign w_capture   = cw_valid && w_cw_ready;

  assign w_chunk     = r_hold[r_idx * Z +: Z];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_idx   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= cw_valid && !w_cw_ready;
      if (w_capture) begin
        // Covers both a capture from IDLE and the no-bubble capture that
        // coincides with the last beat leaving.
        r_hold  <= codeword;
        r_idx   <= '0;
        r_state <= ST_SEND;
      end else if (w_xfer) begin
        if (w_at_last) begin
          r_idx   <= '0;
          r_state <= ST_IDLE;
        end else begin
          r_idx   <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  assign cw_ready  = w_cw_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? w_chunk : '0;
  assign out_idx   = r_idx;
  assign out_last  = w_out_valid && w_at_last;
  assign cw_drop   = r_drop;

endmodule : ldpc_cw_serializer

`default_nettype wire

// File: tb/tb_ldpc_cw_serializer.sv
// ============================================================================
// Module      : tb_ldpc_cw_serializer
// Description : Self-checking bench for ldpc_cw_serializer. Every accepted
//               codeword pushes its expected beats onto a scoreboard queue;
//               the monitor pops and compares as beats hand off.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ldpc_cw_serializer;

  localparam int W  = 648;
  localparam int ZZ = 27;
  localparam int NC = W / ZZ;

  typedef struct packed {
    logic [ZZ-1:0] d;
    logic [4:0]    idx;
    logic          last;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          cw_valid;
  logic [W-1:0]  codeword;
  logic          cw_ready;
  logic          out_valid;
  logic          out_ready;
  logic [ZZ-1:0] out_data;
  logic [4:0]    out_idx;
  logic          out_last;
  logic          cw_drop;

  beat_t sb[$];
  int    n_vec   = 0;
  int    n_err   = 0;
  int    cur_seed = 0;
  logic  exp_drop = 1'b0;
  logic  m_ready;

  ldpc_cw_serializer #(
    .LDPC_WORD_LENGTH (W),
    .Z                (ZZ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cw_valid  (cw_valid),
    .codeword  (codeword),
    .cw_ready  (cw_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .cw_drop   (cw_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ZZ-1:0] chunk_val(input int seed, input int k);
    return ZZ'(k + 1 + seed * 37);
  endfunction

  function automatic logic [W-1:0] make_word(input int seed);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < NC; k++) w[k*ZZ +: ZZ] = chunk_val(seed, k);
    return w;
  endfunction

  // Monitor/scoreboard: sampled on the falling edge, half a cycle from updates.
  always @(negedge clk) begin
    if (!rst) begin
      exp_drop = 1'b0;
    end else begin
      m_ready = (sb.size() == 0) || ((sb.size() == 1) && out_ready);
      check("cw_ready", 64'(cw_ready), 64'(m_ready));
      check("cw_drop", 64'(cw_drop), 64'(exp_drop));
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
        check("out_data", 64'(out_data), 64'(sb[0].d));
        check("out_idx", 64'(out_idx), 64'(sb[0].idx));
        check("out_last", 64'(out_last), 64'(sb[0].last));
        if (out_ready) void'(sb.pop_front());
      end else begin
        check("out_last_idle", 64'(out_last), 64'(0));
      end
      exp_drop = cw_valid && !m_ready;
      if (cw_valid && m_ready) begin
        for (int k = 0; k < NC; k++) begin
          beat_t b;
          b.d    = chunk_val(cur_seed, k);
          b.idx  = 5'(k);
          b.last = (k == NC - 1);
          sb.push_back(b);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send_word(input int seed);
    cur_seed = seed;
    codeword = make_word(seed);
    cw_valid = 1'b1;
    @(posedge clk); #1;
    cw_valid = 1'b0;
  endtask

  // Wait until the scoreboard holds n beats, i.e. beat NC-n is on the bus.
  task automatic wait_q(input int n);
    int t;
    t = 0;
    while ((sb.size() != n) && (t < 300)) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != n) check("wait_timeout", 64'(sb.size()), 64'(n));
  endtask

  initial begin
    rst       = 1'b0;
    cw_valid  = 1'b0;
    codeword  = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_cw_ready", 64'(cw_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_idx", 64'(out_idx), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_cw_drop", 64'(cw_drop), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Single word, full throughput
    send_word(0);
    wait_q(0);
    repeat (2) @(posedge clk); #1;

    // Backpressure at idx 5 for 3 cycles
    send_word(1);
    wait_q(NC - 5);
    out_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    out_ready = 1'b1;
    wait_q(1);

    // Back-to-back: word B offered during the last beat of the previous word
    cur_seed = 2;
    codeword = make_word(2);
    cw_valid = 1'b1;
    @(posedge clk); #1;
    cw_valid = 1'b0;

    // Overflow: word C offered at idx 10 of word B, must be dropped
    wait_q(NC - 10);
    cur_seed = 3;
    codeword = make_word(3);
    cw_valid = 1'b1;
    @(posedge clk); #1;
    cw_valid = 1'b0;
    wait_q(0);
    repeat (2) @(posedge clk); #1;

    // Asynchronous reset at idx 12, between clock edges
    send_word(4);
    wait_q(NC - 12);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_out_data", 64'(out_data), 64'(0));
    check("arst_out_idx", 64'(out_idx), 64'(0));
    check("arst_out_last", 64'(out_last), 64'(0));
    check("arst_cw_ready", 64'(cw_ready), 64'(0));
    check("arst_cw_drop", 64'(cw_drop), 64'(0));
    sb.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send_word(5);
    wait_q(0);
    repeat (3) @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ldpc_cw_serializer

`default_nettype wire
